player_track_ctrl: RTL and testbench

//   Parametrised multi-player track controller for the chicken-race game, generalising the per-player tile counter.

---
 rtl/player_track_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_player_track_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/player_track_ctrl.sv
// player_track_ctrl
//   Turn, position and tail bookkeeping for up to MAX_PLAYERS players on a
//   TRACK_LEN-tile ring. A hit advances the current player one tile and
//   captures any live player it lands on. A miss passes the turn to the next
//   live player. The game ends when one player holds every tail.
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   start            pulse: (re)start a game with num_players (clamped 2..MAX)
//   guess_valid/hit  pulse plus qualifier: current player's guess resolved
//   pos_flat         player k position in [k*POS_W +: POS_W]
//   tails_flat       player k tail count in [k*TAIL_W +: TAIL_W]
//   turn             player to move
//   playing          high while a game is in progress
//   step_pulse       one cycle: current player advanced
//   capture_pulse    one cycle: that advance captured another player
//   game_over        level, high once one player holds all tails
//   winner_id        winning player, valid while game_over
module player_track_ctrl #(
  parameter int MAX_PLAYERS   = 4,
  parameter int TRACK_LEN     = 24,
  parameter int START_SPACING = 6,
  localparam int POS_W  = $clog2(TRACK_LEN),
  localparam int ID_W   = $clog2(MAX_PLAYERS),
  localparam int TAIL_W = $clog2(MAX_PLAYERS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ID_W:0]                 num_players,
  input  logic                          guess_valid,
  input  logic                          guess_hit,
  output logic [MAX_PLAYERS*POS_W-1:0]  pos_flat,
  output logic [MAX_PLAYERS*TAIL_W-1:0] tails_flat,
  output logic [ID_W-1:0]               turn,
  output logic                          playing,
  output logic                          step_pulse,
  output logic                          capture_pulse,
  output logic                          game_over,
  output logic [ID_W-1:0]               winner_id
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_e;

  state_e            state_q, state_d;
  logic [POS_W-1:0]  pos_q   [MAX_PLAYERS];
  logic [POS_W-1:0]  pos_d   [MAX_PLAYERS];
  logic [TAIL_W-1:0] tails_q [MAX_PLAYERS];
  logic [TAIL_W-1:0] tails_d [MAX_PLAYERS];
  logic [ID_W-1:0]   turn_q, turn_d;
  logic [ID_W-1:0]   winner_q, winner_d;
  logic [TAIL_W-1:0] n_q, n_d;
  logic              step_q, step_d;
  logic              capture_q, capture_d;

  // Player count requested on start, clamped to 2..MAX_PLAYERS.
  logic [TAIL_W-1:0] n_start;

  always_comb begin
    if (num_players < (ID_W+1)'(2))
      n_start = TAIL_W'(2);
    else if (num_players > (ID_W+1)'(MAX_PLAYERS))
      n_start = TAIL_W'(MAX_PLAYERS);
    else
      n_start = TAIL_W'(num_players);
  end

  // Hit target and capture victim for the current player.
  logic [POS_W-1:0]       cur_pos, hit_pos;
  logic [MAX_PLAYERS-1:0] cap_mask;
  logic [TAIL_W-1:0]      cap_tails, mover_tails;

  always_comb begin
    cur_pos   = pos_q[turn_q];
    hit_pos   = (cur_pos == POS_W'(TRACK_LEN - 1)) ? '0 : cur_pos + 1'b1;
    cap_mask  = '0;
    cap_tails = '0;
    for (int unsigned k = 0; k < MAX_PLAYERS; k++) begin
      if (ID_W'(k) != turn_q && TAIL_W'(k) < n_q &&
          tails_q[k] != '0 && pos_q[k] == hit_pos) begin
        cap_mask[k] = 1'b1;
        // Live players never share a tile, so at most one victim matches
        // and OR-ing the candidates yields its tail count.
        cap_tails   = cap_tails | tails_q[k];
      end
    end
    mover_tails = tails_q[turn_q] + cap_tails;
  end

  // Next live player after turn_q, wrapping modulo the player count.
  logic [ID_W-1:0] next_turn;
  logic            next_found;
  int unsigned     rot_idx;

  always_comb begin
    next_turn  = turn_q;
    next_found = 1'b0;
    rot_idx    = 0;
    for (int unsigned i = 1; i < MAX_PLAYERS; i++) begin
      rot_idx = 32'(turn_q) + i;
      if (rot_idx >= 32'(n_q))
        rot_idx = rot_idx - 32'(n_q);
      if (!next_found && i < 32'(n_q) && tails_q[ID_W'(rot_idx)] != '0) begin
        next_turn  = ID_W'(rot_idx);
        next_found = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    tails_d   = tails_q;
    turn_d    = turn_q;
    winner_d  = winner_q;
    n_d       = n_q;
    step_d    = 1'b0;
    capture_d = 1'b0;

    if (start) begin
      state_d  = S_PLAY;
      n_d      = n_start;
      turn_d   = '0;
      winner_d = '0;
      for (int unsigned k = 0; k < MAX_PLAYERS; k++) begin
        if (TAIL_W'(k) < n_start) begin
          pos_d[k]   = POS_W'(k * START_SPACING);
          tails_d[k] = TAIL_W'(1);
        end else begin
          pos_d[k]   = '0;
          tails_d[k] = '0;
        end
      end
    end else if (state_q == S_PLAY && guess_valid) begin
      if (guess_hit) begin
        step_d         = 1'b1;
        pos_d[turn_q]  = hit_pos;
        if (cap_mask != '0) begin
          capture_d = 1'b1;
          for (int unsigned k = 0; k < MAX_PLAYERS; k++)
            if (cap_mask[k]) tails_d[k] = '0;
          tails_d[turn_q] = mover_tails;
          // Tails only grow on a capture, so the end check lives here.
          if (mover_tails == n_q) begin
            state_d  = S_OVER;
            winner_d = turn_q;
          end
        end
      end else begin
        turn_d = next_turn;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      turn_q    <= '0;
      winner_q  <= '0;
      n_q       <= '0;
      step_q    <= 1'b0;
      capture_q <= 1'b0;
      for (int unsigned k = 0; k < MAX_PLAYERS; k++) begin
        pos_q[k]   <= '0;
        tails_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      tails_q   <= tails_d;
      turn_q    <= turn_d;
      winner_q  <= winner_d;
      n_q       <= n_d;
      step_q    <= step_d;
      capture_q <= capture_d;
    end
  end

  always_comb begin
    pos_flat   = '0;
    tails_flat = '0;
    for (int unsigned k = 0; k < MAX_PLAYERS; k++) begin
      pos_flat[k*POS_W +: POS_W]    = pos_q[k];
      tails_flat[k*TAIL_W +: TAIL_W] = tails_q[k];
    end
  end

  assign turn          = turn_q;
  assign playing       = (state_q == S_PLAY);
  assign game_over     = (state_q == S_OVER);
  assign winner_id     = winner_q;
  assign step_pulse    = step_q;
  assign capture_pulse = capture_q;

endmodule

// File: tb/tb_player_track_ctrl.sv
// Scoreboard bench for player_track_ctrl: the driver applies one operation per
// cycle and queues the reference model's expected outputs; the monitor pops
// and compares after every rising edge.
module tb_player_track_ctrl;
  localparam int MP     = 4;
  localparam int LEN    = 24;
  localparam int SP     = 6;
  localparam int POS_W  = 5;
  localparam int ID_W   = 2;
  localparam int TAIL_W = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [ID_W:0]          num_players;
  logic                   guess_valid, guess_hit;
  logic [MP*POS_W-1:0]    pos_flat;
  logic [MP*TAIL_W-1:0]   tails_flat;
  logic [ID_W-1:0]        turn, winner_id;
  logic                   playing, step_pulse, capture_pulse, game_over;

  always #5 clk = ~clk;

  player_track_ctrl #(
    .MAX_PLAYERS  (MP),
    .TRACK_LEN    (LEN),
    .START_SPACING(SP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_players  (num_players),
    .guess_valid  (guess_valid),
    .guess_hit    (guess_hit),
    .pos_flat     (pos_flat),
    .tails_flat   (tails_flat),
    .turn         (turn),
    .playing      (playing),
    .step_pulse   (step_pulse),
    .capture_pulse(capture_pulse),
    .game_over    (game_over),
    .winner_id    (winner_id)
  );

  typedef struct {
    logic [MP*POS_W-1:0]  pos;
    logic [MP*TAIL_W-1:0] tails;
    logic [ID_W-1:0]      turn;
    logic                 playing;
    logic                 over;
    logic [ID_W-1:0]      win;
    logic                 step;
    logic                 cap;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference model: game state as plain integers.
  int m_state;  // 0 idle, 1 playing, 2 over
  int m_n, m_turn, m_win;
  int m_pos[MP];
  int m_tails[MP];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_n = 0; m_turn = 0; m_win = 0;
    for (int k = 0; k < MP; k++) begin
      m_pos[k] = 0;
      m_tails[k] = 0;
    end
  endtask

  task automatic model_step(input bit st, input int np, input bit gv, input bit gh,
                            output bit step, output bit cap);
    int np2, t;
    step = 0;
    cap  = 0;
    if (st) begin
      m_n = (np < 2) ? 2 : ((np > MP) ? MP : np);
      for (int k = 0; k < MP; k++) begin
        m_pos[k]   = (k < m_n) ? k * SP : 0;
        m_tails[k] = (k < m_n) ? 1 : 0;
      end
      m_turn = 0; m_win = 0; m_state = 1;
    end else if (m_state == 1 && gv) begin
      if (gh) begin
        step = 1;
        np2 = (m_pos[m_turn] + 1) % LEN;
        for (int j = 0; j < m_n; j++) begin
          if (j != m_turn && m_tails[j] > 0 && m_pos[j] == np2) begin
            m_tails[m_turn] += m_tails[j];
            m_tails[j] = 0;
            cap = 1;
          end
        end
        m_pos[m_turn] = np2;
        if (m_tails[m_turn] == m_n) begin
          m_state = 2;
          m_win = m_turn;
        end
      end else begin
        t = m_turn;
        do t = (t + 1) % m_n; while (m_tails[t] == 0);
        m_turn = t;
      end
    end
  endtask

  function automatic exp_t snap(input bit step, input bit cap);
    exp_t e;
    e.pos = '0;
    e.tails = '0;
    for (int k = 0; k < MP; k++) begin
      e.pos[k*POS_W +: POS_W]    = POS_W'(m_pos[k]);
      e.tails[k*TAIL_W +: TAIL_W] = TAIL_W'(m_tails[k]);
    end
    e.turn    = ID_W'(m_turn);
    e.playing = (m_state == 1);
    e.over    = (m_state == 2);
    e.win     = ID_W'(m_win);
    e.step    = step;
    e.cap     = cap;
    return e;
  endfunction

  // Driver: called at a falling edge, returns at the next falling edge.
  task automatic op(input bit st, input int np, input bit gv, input bit gh);
    bit s, c;
    start       = st;
    num_players = (ID_W+1)'(np);
    guess_valid = gv;
    guess_hit   = gh;
    model_step(st, np, gv, gh, s, c);
    q.push_back(snap(s, c));
    @(negedge clk);
    start       = 1'b0;
    guess_valid = 1'b0;
    guess_hit   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pos"},   64'(pos_flat),   64'(0));
    check({tag, "_tails"}, 64'(tails_flat), 64'(0));
    check({tag, "_turn"},  64'(turn),       64'(0));
    check({tag, "_flags"}, 64'({playing, game_over, step_pulse, capture_pulse}), 64'(0));
    check({tag, "_win"},   64'(winner_id),  64'(0));
  endtask

  // Monitor: outputs are registered, so every edge with a queued operation
  // presents its result just after that edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("pos_flat",   64'(pos_flat),      64'(mon_e.pos));
      check("tails_flat", 64'(tails_flat),    64'(mon_e.tails));
      check("turn",       64'(turn),          64'(mon_e.turn));
      check("playing",    64'(playing),       64'(mon_e.playing));
      check("game_over",  64'(game_over),     64'(mon_e.over));
      check("winner_id",  64'(winner_id),     64'(mon_e.win));
      check("step",       64'(step_pulse),    64'(mon_e.step));
      check("capture",    64'(capture_pulse), 64'(mon_e.cap));
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_players = '0; guess_valid = 1'b0; guess_hit = 1'b0;
    model_reset();
    #1;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Guess while idle is ignored.
    op(0, 0, 1, 1);

    // Three players: fixed start layout.
    op(1, 3, 0, 0);
    check("start3_pos",   64'(pos_flat),   64'h030C0);
    check("start3_tails", 64'(tails_flat), 64'h049);
    check("start3_play",  64'(playing),    64'(1));

    // Misses rotate 0 -> 1 -> 2 -> 0.
    op(0, 0, 1, 0); check("miss_turn1", 64'(turn), 64'(1));
    op(0, 0, 1, 0); check("miss_turn2", 64'(turn), 64'(2));
    op(0, 0, 1, 0); check("miss_turn0", 64'(turn), 64'(0));

    // Clamps.
    op(1, 7, 0, 0);
    check("clamp7_tails", 64'(tails_flat), 64'h249);
    check("clamp7_pos",   64'(pos_flat),   64'h930C0);
    op(1, 0, 0, 0);
    check("clamp0_tails", 64'(tails_flat), 64'h009);

    // Two players: player0 walks onto player1 and wins.
    repeat (6) op(0, 0, 1, 1);
    check("cap2_tails", 64'(tails_flat),    64'h002);
    check("cap2_over",  64'(game_over),     64'(1));
    check("cap2_cap",   64'(capture_pulse), 64'(1));
    check("cap2_win",   64'(winner_id),     64'(0));
    op(0, 0, 1, 1);  // ignored while over
    check("over_nostep", 64'(step_pulse), 64'(0));

    // Start and guess in the same cycle: only the fresh init happens.
    op(1, 4, 1, 1);
    check("startgv_pos", 64'(pos_flat), 64'h930C0);

    // Player1 captures player2, then a miss skips the eliminated player.
    op(0, 0, 1, 0);
    repeat (6) op(0, 0, 1, 1);
    check("skip_tails", 64'(tails_flat), 64'h211);
    op(0, 0, 1, 0);
    check("skip_turn", 64'(turn), 64'(3));

    // Player3 runs 18 -> 23 -> 0 (wrap), capturing player0 at tile 0.
    repeat (5) op(0, 0, 1, 1);
    check("pre_wrap_pos3", 64'(pos_flat[3*POS_W +: POS_W]), 64'(23));
    op(0, 0, 1, 1);
    check("wrap_pos3",  64'(pos_flat[3*POS_W +: POS_W]), 64'(0));
    check("wrap_step",  64'(step_pulse),    64'(1));
    check("wrap_cap",   64'(capture_pulse), 64'(1));
    check("wrap_tails", 64'(tails_flat),    64'h410);
    op(0, 0, 1, 0);

    // Asynchronous reset mid-game.
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomised play.
    for (int i = 0; i < 2000; i++) begin
      if (m_state != 1 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) < 2))
        op(1, int'($urandom_range(0, 7)), $urandom_range(0, 1), $urandom_range(0, 1));
      else
        op(0, int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 99) < 60));
    end

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) check("queue_drained", 64'(q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
